// File: rtl/fb_scaler_vga.sv
// Raster timing generator that reads a SRC_W x SRC_H frame buffer from BRAM, replicates it 1x/2x/4x
// into a window of the active area, and delays sync/den so they leave aligned with the BRAM data.
module fb_scaler_vga #(
    parameter int               H_SYNC     = 96,
    parameter int               H_BP       = 48,
    parameter int               H_ACT      = 640,
    parameter int               H_FP       = 16,
    parameter bit               H_POL      = 1'b1,
    parameter int               V_SYNC     = 2,
    parameter int               V_BP       = 33,
    parameter int               V_ACT      = 480,
    parameter int               V_FP       = 10,
    parameter bit               V_POL      = 1'b1,
    parameter int               SRC_W      = 320,
    parameter int               SRC_H      = 180,
    parameter int               SCALE_LOG2 = 0,
    parameter int               X_OFS      = 0,
    parameter int               Y_OFS      = 0,
    parameter int               ADDR_W     = 20,
    parameter int               PIX_W      = 24,
    parameter int               RD_LAT     = 1,
    parameter logic [PIX_W-1:0] BG_COLOR   = 24'hff00ff
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              hsync,
    output logic              vsync,
    output logic              den,
    output logic [PIX_W-1:0]  rgb,
    output logic              frame_start
);
    localparam int     H_TOT     = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int     V_TOT     = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int     HC_W      = $clog2(H_TOT);
    localparam int     VC_W      = $clog2(V_TOT);
    localparam int     H_ACT0    = H_SYNC + H_BP;
    localparam int     V_ACT0    = V_SYNC + V_BP;
    localparam int     WIN_X0    = H_ACT0 + X_OFS;
    localparam int     WIN_Y0    = V_ACT0 + Y_OFS;
    localparam int     WIN_W     = SRC_W << SCALE_LOG2;
    localparam int     WIN_H     = SRC_H << SCALE_LOG2;
    localparam int     REP       = 1 << SCALE_LOG2;
    localparam int     RW        = ADDR_W + 1;
    localparam longint SRC_PIX   = longint'(SRC_W) * longint'(SRC_H);
    localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

    if (SRC_PIX > ADDR_SPAN) begin : g_bad_size
        $error("fb_scaler_vga: SRC_W*SRC_H does not fit in the BRAM address space");
    end
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_bad_scale
        $error("fb_scaler_vga: SCALE_LOG2 must be 0..2");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("fb_scaler_vga: RD_LAT must be 1..4");
    end

    logic [HC_W-1:0] hcnt;
    logic [VC_W-1:0] vcnt;
    int              hpos, vpos;
    logic            line_end, frame_end, h_act, v_act, x_in, y_in, in_win;
    logic            hs_now, vs_now, fs_now;

    assign hpos      = int'(hcnt);
    assign vpos      = int'(vcnt);
    assign line_end  = (hpos == H_TOT - 1);
    assign frame_end = (vpos == V_TOT - 1);
    assign h_act     = (hpos >= H_ACT0) && (hpos < H_ACT0 + H_ACT);
    assign v_act     = (vpos >= V_ACT0) && (vpos < V_ACT0 + V_ACT);
    assign x_in      = (hpos >= WIN_X0) && (hpos < WIN_X0 + WIN_W);
    assign y_in      = (vpos >= WIN_Y0) && (vpos < WIN_Y0 + WIN_H);
    assign in_win    = h_act && v_act && x_in && y_in;
    assign hs_now    = (hpos < H_SYNC) ? H_POL : ~H_POL;
    assign vs_now    = (vpos < V_SYNC) ? V_POL : ~V_POL;
    assign fs_now    = (hcnt == '0) && (vcnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (en) begin
            if (line_end) begin
                hcnt <= '0;
                vcnt <= frame_end ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Column/row stepping follows the unclipped window extent so clipped pixels still advance the address.
    logic [RW-1:0]     row_base, col;
    logic [1:0]        hrep, vrep;
    logic [ADDR_W-1:0] addr_hold, cur_addr;

    assign cur_addr = ADDR_W'(row_base + col);
    assign ram_re   = in_win;
    assign ram_addr = in_win ? cur_addr : addr_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            hrep      <= '0;
            row_base  <= '0;
            vrep      <= '0;
            addr_hold <= '0;
        end else if (en) begin
            if (in_win)
                addr_hold <= cur_addr;
            if (line_end) begin
                col  <= '0;
                hrep <= '0;
            end else if (x_in) begin
                if (hrep == 2'(REP - 1)) begin
                    hrep <= '0;
                    col  <= col + 1'b1;
                end else begin
                    hrep <= hrep + 1'b1;
                end
            end
            if (vpos < V_SYNC) begin
                row_base <= '0;
                vrep     <= '0;
            end else if (line_end && y_in) begin
                if (vrep == 2'(REP - 1)) begin
                    vrep     <= '0;
                    row_base <= row_base + RW'(SRC_W);
                end else begin
                    vrep <= vrep + 1'b1;
                end
            end
        end
    end

    // RD_LAT-deep delay line matches the BRAM; the registered output stage adds the final cycle.
    logic [RD_LAT-1:0] hs_d, vs_d, den_d, win_d, fs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d  <= {RD_LAT{~H_POL}};
            vs_d  <= {RD_LAT{~V_POL}};
            den_d <= '0;
            win_d <= '0;
            fs_d  <= '0;
        end else if (en) begin
            hs_d[0]  <= hs_now;
            vs_d[0]  <= vs_now;
            den_d[0] <= h_act && v_act;
            win_d[0] <= in_win;
            fs_d[0]  <= fs_now;
            for (int i = 1; i < RD_LAT; i++) begin
                hs_d[i]  <= hs_d[i-1];
                vs_d[i]  <= vs_d[i-1];
                den_d[i] <= den_d[i-1];
                win_d[i] <= win_d[i-1];
                fs_d[i]  <= fs_d[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            den         <= 1'b0;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else if (en) begin
            hsync       <= hs_d[RD_LAT-1];
            vsync       <= vs_d[RD_LAT-1];
            den         <= den_d[RD_LAT-1];
            frame_start <= fs_d[RD_LAT-1];
            if (win_d[RD_LAT-1])
                rgb <= ram_rdata;
            else if (den_d[RD_LAT-1])
                rgb <= BG_COLOR;
            else
                rgb <= '0;
        end
    end
endmodule

// File: tb/tb_fb_scaler_vga.sv
// Scoreboard bench for fb_scaler_vga on a shrunken raster: 2x replication, clipped window, RD_LAT=2,
// random clock-enable gaps and a mid-frame reset.
module tb_fb_scaler_vga;
    localparam int          H_SYNC = 4, H_BP = 3, H_ACT = 16, H_FP = 2;
    localparam int          V_SYNC = 2, V_BP = 2, V_ACT = 10, V_FP = 1;
    localparam bit          H_POL = 1'b1, V_POL = 1'b0;
    localparam int          SRC_W = 6, SRC_H = 4, SCALE_LOG2 = 1, X_OFS = 8, Y_OFS = 4;
    localparam int          ADDR_W = 8, PIX_W = 24, RD_LAT = 2;
    localparam logic [23:0] BG_COLOR = 24'hff00ff;
    localparam int          H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int          V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int          LAT = RD_LAT + 1;
    localparam int          FRAME = H_TOT * V_TOT;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             den;
        logic             fs;
        logic [PIX_W-1:0] rgb;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst, en;
    logic [PIX_W-1:0]  ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re, hsync, vsync, den, frame_start;
    logic [PIX_W-1:0]  rgb;

    always #5 clk = ~clk;

    fb_scaler_vga #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP), .H_POL(H_POL),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP), .V_POL(V_POL),
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE_LOG2(SCALE_LOG2), .X_OFS(X_OFS), .Y_OFS(Y_OFS),
        .ADDR_W(ADDR_W), .PIX_W(PIX_W), .RD_LAT(RD_LAT), .BG_COLOR(BG_COLOR)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ram_rdata(ram_rdata), .ram_addr(ram_addr),
        .ram_re(ram_re), .hsync(hsync), .vsync(vsync), .den(den), .rgb(rgb),
        .frame_start(frame_start)
    );

    function automatic logic [PIX_W-1:0] bram_word(input int a);
        return 24'h800000 | PIX_W'(a);
    endfunction

    // BRAM model: data emerges RD_LAT enabled edges after the address.
    logic [PIX_W-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        if (en) begin
            bram_pipe[0] <= bram_word(int'(ram_addr));
            for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
        end
    end
    assign ram_rdata = bram_pipe[RD_LAT-1];

    int   mh, mv, last_addr, tests, fails;
    exp_t q[$];
    exp_t cur;
    bit   tally;
    int   den_cnt, re_cnt, fs_cnt, hs_cnt, vs_cnt, max_addr;

    function automatic bit win_at(input int h, input int v);
        int x, y;
        bit act;
        act = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACT) &&
              (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACT);
        x = h - (H_SYNC + H_BP + X_OFS);
        y = v - (V_SYNC + V_BP + Y_OFS);
        return act && x >= 0 && x < (SRC_W << SCALE_LOG2) && y >= 0 && y < (SRC_H << SCALE_LOG2);
    endfunction

    function automatic int addr_at(input int h, input int v);
        int x, y;
        x = h - (H_SYNC + H_BP + X_OFS);
        y = v - (V_SYNC + V_BP + Y_OFS);
        return (y >> SCALE_LOG2) * SRC_W + (x >> SCALE_LOG2);
    endfunction

    function automatic exp_t expect_at(input int h, input int v);
        exp_t e;
        bit   act;
        act   = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACT) &&
                (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACT);
        e.hs  = (h < H_SYNC) ? H_POL : ~H_POL;
        e.vs  = (v < V_SYNC) ? V_POL : ~V_POL;
        e.den = act;
        e.fs  = (h == 0) && (v == 0);
        e.rgb = win_at(h, v) ? bram_word(addr_at(h, v)) : (act ? BG_COLOR : '0);
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.hs  = ~H_POL;
        e.vs  = ~V_POL;
        e.den = 1'b0;
        e.fs  = 1'b0;
        e.rgb = '0;
        return e;
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        last_addr = 0;
        q.delete();
        cur = reset_exp();
        for (int i = 0; i < LAT - 1; i++) q.push_back(reset_exp());
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s at h=%0d v=%0d: observed %h expected %h", tag, mh, mv, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare at the falling edge.
    task automatic apply_stimulus(input logic en_v, input logic rst_v);
        en  = en_v;
        rst = rst_v;
        @(posedge clk);
        if (rst_v) begin
            model_reset();
        end else if (en_v) begin
            q.push_back(expect_at(mh, mv));
            cur = q.pop_front();
            if (win_at(mh, mv)) last_addr = addr_at(mh, mv);
            if (mh == H_TOT - 1) begin
                mh = 0;
                mv = (mv == V_TOT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        @(negedge clk);
        check_output("hsync", 32'(hsync), 32'(cur.hs));
        check_output("vsync", 32'(vsync), 32'(cur.vs));
        check_output("den", 32'(den), 32'(cur.den));
        check_output("frame_start", 32'(frame_start), 32'(cur.fs));
        check_output("rgb", 32'(rgb), 32'(cur.rgb));
        check_output("ram_re", 32'(ram_re), 32'(win_at(mh, mv)));
        check_output("ram_addr", 32'(ram_addr), 32'(win_at(mh, mv) ? addr_at(mh, mv) : last_addr));
        if (tally) begin
            den_cnt += int'(den);
            re_cnt  += int'(ram_re);
            fs_cnt  += int'(frame_start);
            hs_cnt  += int'(hsync == H_POL);
            vs_cnt  += int'(vsync == V_POL);
            if (ram_re && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        end
    endtask

    initial begin
        logic e;
        tests = 0;
        fails = 0;
        tally = 1'b0;
        den_cnt = 0; re_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; max_addr = 0;
        model_reset();

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1);
        for (int i = 0; i < FRAME; i++) apply_stimulus(1'b1, 1'b0);

        // A full frame period of outputs gives exact per-frame totals regardless of phase.
        tally = 1'b1;
        for (int i = 0; i < FRAME; i++) apply_stimulus(1'b1, 1'b0);
        tally = 1'b0;
        check_output("den_per_frame", 32'(den_cnt), 32'(H_ACT * V_ACT));
        check_output("re_per_frame", 32'(re_cnt), 32'd48);
        check_output("fs_per_frame", 32'(fs_cnt), 32'd1);
        check_output("hsync_per_frame", 32'(hs_cnt), 32'(H_SYNC * V_TOT));
        check_output("vsync_per_frame", 32'(vs_cnt), 32'(V_SYNC * H_TOT));
        check_output("max_read_addr", 32'(max_addr), 32'd15);

        for (int i = 0; i < 2 * FRAME; i++) begin
            e = ($urandom_range(0, 1) != 0);
            apply_stimulus(e, 1'b0);
        end

        for (int i = 0; i < FRAME && !(mv == 7 && mh == 10); i++) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        for (int i = 0; i < FRAME + 60; i++) apply_stimulus(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
